// File: rtl/ifft_player_pkg.sv
// ifft_player_pkg
// Shared definitions for the IFFT frame player: the read-side state
// enum, the bank count, the DAC midscale code and the helper that
// saturates a rescaled sample and turns it into an offset-binary code.
// No ports; imported by the player and its testbench.

package ifft_player_pkg;

    // Read-side sequencer states
    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        STARVE
    } rd_state_t;

    localparam int NUM_BANKS = 2;

    // Midscale code for the default 14-bit DAC (zero volts out)
    localparam int unsigned DEF_DAC_W = 14;
    localparam logic [DEF_DAC_W-1:0] MIDSCALE = 14'h2000;

    // Clamp a signed value to the signed dac_w range, then flip the MSB
    // to get offset-binary. Only the low dac_w bits of the result matter.
    function automatic logic [31:0] sat_offset(input logic signed [31:0] s,
                                               input int dac_w);
        logic signed [31:0] lim_hi;
        logic signed [31:0] lim_lo;
        logic signed [31:0] c;
        lim_hi = (32'sd1 <<< (dac_w - 1)) - 32'sd1;
        lim_lo = -lim_hi - 32'sd1;
        if (s > lim_hi) begin
            c = lim_hi;
        end else if (s < lim_lo) begin
            c = lim_lo;
        end else begin
            c = s;
        end
        return c ^ (32'sd1 <<< (dac_w - 1));
    endfunction

endpackage

// File: rtl/ifft_frame_player_if.sv
// ifft_frame_player_if
// Groups the IFFT sample stream, the DAC sample-rate tick and the DAC
// output stream of the frame player.
//   i_valid/i_data/i_last : bursty IFFT real-part samples with frame marker
//   dac_tick              : one-cycle sample-rate enable
//   o_dac/o_valid         : offset-binary DAC code and its update strobe
//   o_frame_start         : marks sample 0 of a replayed frame
// master = upstream/driver side, slave = the player.

interface ifft_frame_player_if #(
    parameter int IN_W  = 16,
    parameter int DAC_W = 14
);
    logic             i_valid;
    logic [IN_W-1:0]  i_data;
    logic             i_last;
    logic             dac_tick;
    logic [DAC_W-1:0] o_dac;
    logic             o_valid;
    logic             o_frame_start;

    modport master (
        output i_valid, i_data, i_last, dac_tick,
        input  o_dac, o_valid, o_frame_start
    );

    modport slave (
        input  i_valid, i_data, i_last, dac_tick,
        output o_dac, o_valid, o_frame_start
    );
endinterface

// File: rtl/pingpong_ram.sv
// pingpong_ram
// Simple dual-port RAM holding both frame banks, address {bank, idx}.
//   clk          : clock
//   we/waddr/wdata : synchronous write port
//   re/raddr     : read enable and address
//   rdata        : registered read data, valid the cycle after re
// No reset so it maps onto block RAM.

module pingpong_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Write-first is irrelevant here: a bank is never written while it is read
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/ifft_frame_player.sv
// ifft_frame_player
// Captures IFFT output frames into a ping-pong buffer and replays them
// at the DAC sample rate, rescaled, saturated and in offset binary.
//   clk, rst     : clock and asynchronous active-high reset
//   bus (slave)  : IFFT input stream, dac_tick, DAC output stream
//   clr_flags    : clears the sticky flags (a same-cycle event wins)
//   o_underrun   : tick arrived while starved of a full bank
//   o_overflow   : frame dropped because its target bank was still full
//   o_frame_err  : i_last did not coincide with the last bank slot

module ifft_frame_player
    import ifft_player_pkg::*;
#(
    parameter int FFT_POINT  = 8192,
    parameter int IN_W       = 16,
    parameter int DAC_W      = 14,
    parameter int GAIN_SHIFT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    ifft_frame_player_if.slave   bus,
    input  logic                 clr_flags,
    output logic                 o_underrun,
    output logic                 o_overflow,
    output logic                 o_frame_err
);
    localparam int AW = $clog2(FFT_POINT);
    localparam logic [AW-1:0] LAST_IDX = AW'(FFT_POINT - 1);
    localparam logic [DAC_W-1:0] MID = {1'b1, {(DAC_W-1){1'b0}}};

    logic [AW-1:0]        wr_cnt;
    logic [AW-1:0]        rd_cnt;
    logic                 wr_bank;
    logic                 rd_bank;
    logic                 wr_drop;
    logic [NUM_BANKS-1:0] full;
    rd_state_t            state;
    logic                 p_valid;
    logic                 p_start;
    logic                 p_mid;
    logic [IN_W-1:0]      ram_q;

    logic wr_fire, wr_ovf, wr_en, wr_at_last, wr_done, wr_err;
    logic rd_fire, rd_release, starve_tick, other_bank, next_full;

    // A frame arriving at an occupied bank is refused on its first sample;
    // a length error is any mismatch between i_last and the last slot.
    always_comb begin
        wr_fire     = bus.i_valid & ~wr_drop;
        wr_ovf      = wr_fire & (wr_cnt == '0) & full[wr_bank];
        wr_en       = wr_fire & ~wr_ovf;
        wr_at_last  = (wr_cnt == LAST_IDX);
        wr_done     = wr_en & bus.i_last & wr_at_last;
        wr_err      = wr_en & (bus.i_last ^ wr_at_last);
        rd_fire     = (state == PLAY) & bus.dac_tick;
        rd_release  = rd_fire & (rd_cnt == LAST_IDX);
        starve_tick = (state == STARVE) & bus.dac_tick;
        other_bank  = ~rd_bank;
        // Look through a same-cycle write completion so back-to-back
        // frames do not glitch through STARVE
        next_full   = full[other_bank] | (wr_done & (wr_bank == other_bank));
    end

    // Write side: fill the current bank, or discard until the next i_last
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
            wr_drop <= 1'b1;
        end else if (bus.i_valid) begin
            if (wr_drop) begin
                if (bus.i_last) begin
                    wr_drop <= 1'b0;
                    wr_cnt  <= '0;
                end
            end else if (wr_ovf) begin
                wr_drop <= ~bus.i_last;
            end else if (bus.i_last) begin
                wr_cnt <= '0;
                if (wr_at_last) begin
                    wr_bank <= ~wr_bank;
                end
            end else if (wr_at_last) begin
                wr_cnt  <= '0;
                wr_drop <= 1'b1;
            end else begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end

    // Bank occupancy: set by a completed write, cleared when playback
    // releases it; the two never target the same bank in one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (wr_done && (wr_bank == b[0])) begin
                    full[b] <= 1'b1;
                end else if (rd_release && (rd_bank == b[0])) begin
                    full[b] <= 1'b0;
                end
            end
        end
    end

    // Read sequencer: issues RAM reads on ticks and tags each slot for the
    // format stage (valid, frame start, or a midscale filler when starved)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
            p_valid <= 1'b0;
            p_start <= 1'b0;
            p_mid   <= 1'b0;
        end else begin
            p_valid <= 1'b0;
            p_start <= 1'b0;
            p_mid   <= 1'b0;
            case (state)
                IDLE: begin
                    if (full[rd_bank]) begin
                        state  <= PLAY;
                        rd_cnt <= '0;
                    end
                end
                PLAY: begin
                    if (bus.dac_tick) begin
                        p_valid <= 1'b1;
                        p_start <= (rd_cnt == '0);
                        if (rd_cnt == LAST_IDX) begin
                            rd_cnt  <= '0;
                            rd_bank <= other_bank;
                            state   <= next_full ? PLAY : STARVE;
                        end else begin
                            rd_cnt <= rd_cnt + 1'b1;
                        end
                    end
                end
                STARVE: begin
                    if (bus.dac_tick) begin
                        p_valid <= 1'b1;
                        p_mid   <= 1'b1;
                    end
                    if (full[rd_bank]) begin
                        state  <= PLAY;
                        rd_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    pingpong_ram #(
        .DEPTH (NUM_BANKS * FFT_POINT),
        .WIDTH (IN_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr ({wr_bank, wr_cnt}),
        .wdata (bus.i_data),
        .re    (rd_fire),
        .raddr ({rd_bank, rd_cnt}),
        .rdata (ram_q)
    );

    // Format stage: gain shift, saturate, offset binary; o_dac holds between ticks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.o_dac         <= MID;
            bus.o_valid       <= 1'b0;
            bus.o_frame_start <= 1'b0;
        end else begin
            bus.o_valid       <= p_valid;
            bus.o_frame_start <= p_start;
            if (p_valid) begin
                bus.o_dac <= p_mid ? MID
                    : DAC_W'(sat_offset(32'($signed(ram_q)) >>> GAIN_SHIFT, DAC_W));
            end
        end
    end

    // Sticky flags; a new event in the same cycle as clr_flags keeps the flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_underrun  <= 1'b0;
            o_overflow  <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            if (starve_tick)    o_underrun  <= 1'b1;
            else if (clr_flags) o_underrun  <= 1'b0;
            if (wr_ovf)         o_overflow  <= 1'b1;
            else if (clr_flags) o_overflow  <= 1'b0;
            if (wr_err)         o_frame_err <= 1'b1;
            else if (clr_flags) o_frame_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ifft_frame_player.sv
// tb_ifft_frame_player
// Self-checking bench for ifft_frame_player with 16-point frames.
// A behavioural model tracks the frames waiting to be played as a queue
// of expected DAC codes; an output monitor compares every o_valid sample
// against the codes the model queued when the corresponding tick was issued.

module tb_ifft_frame_player;
    import ifft_player_pkg::*;

    localparam int N = 16;
    localparam int MID_CODE = int'(MIDSCALE);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr_flags = 1'b0;
    logic o_underrun, o_overflow, o_frame_err;

    int checks = 0;
    int failures = 0;

    // Model state
    int  frame_buf [32];
    int  exp_samp[$];
    int  exp_q[$];
    bit  m_drop = 1'b1;
    bit  m_started = 1'b0;
    bit  m_under = 1'b0;
    bit  m_ovf = 1'b0;
    bit  m_err = 1'b0;

    ifft_frame_player_if #(.IN_W(16), .DAC_W(14)) bus ();

    ifft_frame_player #(
        .FFT_POINT  (N),
        .IN_W       (16),
        .DAC_W      (14),
        .GAIN_SHIFT (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .clr_flags   (clr_flags),
        .o_underrun  (o_underrun),
        .o_overflow  (o_overflow),
        .o_frame_err (o_frame_err)
    );

    always #5 clk = ~clk;

    // Expected DAC code: divide by 4 rounding down, clamp, shift to offset binary
    function automatic int code_of(input int d);
        int s;
        s = d >>> 2;
        if (s > 8191) s = 8191;
        if (s < -8192) s = -8192;
        return s + 8192;
    endfunction

    // A frame is taken only if no drop is pending, fewer than two frames
    // are waiting, and it has exactly N samples
    function automatic void model_frame(input int n);
        if (m_drop) begin
            m_drop = 1'b0;
        end else if ((exp_samp.size() + N - 1) / N >= 2) begin
            m_ovf = 1'b1;
        end else if (n != N) begin
            m_err = 1'b1;
        end else begin
            for (int k = 0; k < N; k++) begin
                exp_samp.push_back(((k == 0) ? 65536 : 0) + code_of(frame_buf[k]));
            end
            m_started = 1'b1;
        end
    endfunction

    function automatic void model_tick();
        if (exp_samp.size() > 0) begin
            exp_q.push_back(exp_samp.pop_front());
        end else if (m_started) begin
            exp_q.push_back(MID_CODE);
            m_under = 1'b1;
        end
    endfunction

    // Output monitor: every o_valid sample must match the next queued expectation
    always @(negedge clk) begin
        int obs;
        int e;
        if (bus.o_valid === 1'b1) begin
            obs = (bus.o_frame_start ? 65536 : 0) + int'(bus.o_dac);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL out_extra got fs=%0d dac=%h required no output",
                         obs / 65536, obs % 65536);
            end else begin
                e = exp_q.pop_front();
                if (obs !== e) begin
                    failures++;
                    $display("[TB] FAIL out_sample got fs=%0d dac=%h required fs=%0d dac=%h",
                             obs / 65536, obs % 65536, e / 65536, e % 65536);
                end
            end
        end else if (bus.o_frame_start !== 1'b0) begin
            checks++;
            failures++;
            $display("[TB] FAIL frame_start_idle got %b required 0", bus.o_frame_start);
        end
    end

    task automatic fill_random();
        for (int k = 0; k < 32; k++) begin
            frame_buf[k] = int'($signed(16'($urandom)));
        end
    endtask

    task automatic send_frame(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            bus.i_valid = 1'b1;
            bus.i_data  = 16'(frame_buf[k]);
            bus.i_last  = (k == n - 1);
        end
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        model_frame(n);
    endtask

    task automatic tick_n(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.dac_tick = 1'b1;
            model_tick();
            if (gap > 0) begin
                @(posedge clk); #1;
                bus.dac_tick = 1'b0;
                repeat (gap - 1) @(posedge clk);
            end
        end
        @(posedge clk); #1;
        bus.dac_tick = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic clear_flags();
        @(posedge clk); #1;
        clr_flags = 1'b1;
        @(posedge clk); #1;
        clr_flags = 1'b0;
        m_under = 1'b0;
        m_ovf = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_samp.delete();
        m_drop = 1'b1;
        m_started = 1'b0;
        m_under = 1'b0;
        m_ovf = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.o_dac !== MIDSCALE) begin
            failures++;
            $display("[TB] FAIL reset_dac got %h required %h", bus.o_dac, MIDSCALE);
        end
        checks++;
        if ({bus.o_valid, bus.o_frame_start} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL reset_valid got %b required 00", {bus.o_valid, bus.o_frame_start});
        end
        checks++;
        if ({o_underrun, o_overflow, o_frame_err} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_flags got %b required 000", {o_underrun, o_overflow, o_frame_err});
        end
        rst = 1'b0;
        // Ticks before any frame are startup silence, not underruns
        tick_n(3, 0);
        drain();
        checks++;
        if (o_underrun !== m_under) begin
            failures++;
            $display("[TB] FAIL idle_underrun got %b required %b", o_underrun, m_under);
        end
        // The first partial frame after reset is discarded without error
        fill_random();
        send_frame(5);
        checks++;
        if ({o_overflow, o_frame_err} !== {m_ovf, m_err}) begin
            failures++;
            $display("[TB] FAIL sync_drop_flags got %b required %b",
                     {o_overflow, o_frame_err}, {m_ovf, m_err});
        end
    endtask

    task automatic test_basic();
        for (int k = 0; k < N; k++) frame_buf[k] = 4 * k;
        send_frame(N);
        settle();
        @(posedge clk); #1;
        bus.dac_tick = 1'b1;
        model_tick();
        @(posedge clk); #1;
        bus.dac_tick = 1'b0;
        checks++;
        if (bus.o_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL latency_early got o_valid=%b required 0", bus.o_valid);
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.o_valid, bus.o_frame_start, bus.o_dac} !== {2'b11, 14'h2000}) begin
            failures++;
            $display("[TB] FAIL latency_first got v=%b fs=%b dac=%h required v=1 fs=1 dac=2000",
                     bus.o_valid, bus.o_frame_start, bus.o_dac);
        end
        tick_n(N - 1, 0);
        drain();
        checks++;
        if (exp_q.size() != 0 || o_underrun !== m_under) begin
            failures++;
            $display("[TB] FAIL basic_done got pending=%0d underrun=%b required 0 %b",
                     exp_q.size(), o_underrun, m_under);
        end
    endtask

    task automatic test_saturation();
        fill_random();
        frame_buf[0] = 32767;
        frame_buf[1] = -32768;
        frame_buf[2] = -4;
        frame_buf[3] = 3;
        frame_buf[15] = -32765;
        send_frame(N);
        settle();
        tick_n(N, 1);
        drain();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL sat_missing got pending=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_underrun();
        fill_random();
        send_frame(N);
        settle();
        tick_n(N + 4, 0);
        drain();
        checks++;
        if (exp_q.size() != 0 || o_underrun !== m_under) begin
            failures++;
            $display("[TB] FAIL underrun_set got pending=%0d underrun=%b required 0 %b",
                     exp_q.size(), o_underrun, m_under);
        end
        // Clear arriving with another starved tick: the tick wins
        @(posedge clk); #1;
        bus.dac_tick = 1'b1;
        clr_flags = 1'b1;
        model_tick();
        @(posedge clk); #1;
        bus.dac_tick = 1'b0;
        clr_flags = 1'b0;
        drain();
        checks++;
        if (o_underrun !== m_under) begin
            failures++;
            $display("[TB] FAIL clr_vs_event got %b required %b", o_underrun, m_under);
        end
        clear_flags();
        checks++;
        if (o_underrun !== m_under) begin
            failures++;
            $display("[TB] FAIL underrun_clear got %b required %b", o_underrun, m_under);
        end
        fill_random();
        send_frame(N);
        settle();
        tick_n(N, 0);
        drain();
        checks++;
        if (exp_q.size() != 0 || o_underrun !== m_under) begin
            failures++;
            $display("[TB] FAIL resume got pending=%0d underrun=%b required 0 %b",
                     exp_q.size(), o_underrun, m_under);
        end
    endtask

    task automatic test_overflow();
        for (int f = 0; f < 3; f++) begin
            fill_random();
            send_frame(N);
        end
        checks++;
        if (o_overflow !== m_ovf) begin
            failures++;
            $display("[TB] FAIL overflow_set got %b required %b", o_overflow, m_ovf);
        end
        settle();
        tick_n(2 * N + 4, 0);
        drain();
        checks++;
        if (exp_q.size() != 0 || {o_underrun, o_overflow} !== {m_under, m_ovf}) begin
            failures++;
            $display("[TB] FAIL overflow_play got pending=%0d flags=%b required 0 %b",
                     exp_q.size(), {o_underrun, o_overflow}, {m_under, m_ovf});
        end
        clear_flags();
    endtask

    task automatic test_frame_err();
        fill_random();
        send_frame(10);
        checks++;
        if (o_frame_err !== m_err) begin
            failures++;
            $display("[TB] FAIL short_frame got %b required %b", o_frame_err, m_err);
        end
        settle();
        tick_n(3, 0);
        drain();
        fill_random();
        send_frame(N + 4);
        clear_flags();
        fill_random();
        send_frame(N);
        settle();
        tick_n(N, 0);
        drain();
        checks++;
        if (exp_q.size() != 0 || {o_underrun, o_overflow, o_frame_err} !== {m_under, m_ovf, m_err}) begin
            failures++;
            $display("[TB] FAIL err_recover got pending=%0d flags=%b required 0 %b",
                     exp_q.size(), {o_underrun, o_overflow, o_frame_err}, {m_under, m_ovf, m_err});
        end
    endtask

    task automatic test_back_to_back();
        fill_random();
        send_frame(N);
        settle();
        fork
            tick_n(2 * N, 1);
            begin
                fill_random();
                send_frame(N);
            end
        join
        drain();
        checks++;
        if (exp_q.size() != 0 || {o_underrun, o_overflow} !== {m_under, m_ovf}) begin
            failures++;
            $display("[TB] FAIL back_to_back got pending=%0d flags=%b required 0 %b",
                     exp_q.size(), {o_underrun, o_overflow}, {m_under, m_ovf});
        end
    endtask

    task automatic test_reset_midplay();
        int want;
        fill_random();
        send_frame(5);
        fill_random();
        frame_buf[7] = 20000;
        send_frame(N);
        settle();
        tick_n(8, 0);
        drain();
        want = code_of(frame_buf[7]);
        checks++;
        if (int'(bus.o_dac) !== want || o_frame_err !== m_err) begin
            failures++;
            $display("[TB] FAIL pre_reset got dac=%h err=%b required %h %b",
                     bus.o_dac, o_frame_err, want, m_err);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (bus.o_dac !== MIDSCALE || {o_underrun, o_overflow, o_frame_err} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL midplay_reset got dac=%h flags=%b required %h 000",
                     bus.o_dac, {o_underrun, o_overflow, o_frame_err}, MIDSCALE);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick_n(3, 0);
        drain();
        fill_random();
        send_frame(7);
        checks++;
        if ({o_underrun, o_frame_err} !== {m_under, m_err}) begin
            failures++;
            $display("[TB] FAIL inflight_drop got %b required %b",
                     {o_underrun, o_frame_err}, {m_under, m_err});
        end
        fill_random();
        send_frame(N);
        settle();
        tick_n(N, 0);
        drain();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL post_reset_play got pending=%0d required 0", exp_q.size());
        end
    endtask

    initial begin
        bus.i_valid  = 1'b0;
        bus.i_data   = '0;
        bus.i_last   = 1'b0;
        bus.dac_tick = 1'b0;
        test_reset();
        test_basic();
        test_saturation();
        test_underrun();
        test_overflow();
        test_frame_err();
        test_back_to_back();
        test_reset_midplay();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
